crc_frame_engine: RTL
=====================

CRC_FRAME_ENGINE -- requirements
Module: crc_frame_engine

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- CRC_W, 16, CRC width in bits (2..64).
- DATA_W, 8, data bits consumed per accepted beat (1..64).
- POLY, 16'h1021, generator polynomial without the implicit x^CRC_W term.
- INIT, all ones, register seed at frame start.
- XOROUT, 0, value XORed into the final result.
- REFIN, 0, 1 = each beat processed LSB-first; 0 = MSB-first.
- REFOUT, 0, 1 = final register bit-reversed before XOROUT.
- RESIDUE, 0, expected final result in check mode.
- LEN_W, 16, width of the beat counter.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, beat offered.
- in_ready, out, 1, engine accepts a beat.
- in_data, in, DATA_W, beat payload.
- in_last, in, 1, beat is the last of its frame.
- in_chk, in, 1, mode sampled on the first beat: 0 = generate, 1 = check.
- abort, in, 1, discard the current frame.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer takes the result.
- crc_out, out, CRC_W, final result.
- crc_error, out, 1, check-mode mismatch.
- out_len, out, LEN_W, accepted beats in the frame.
- busy, out, 1, frame in progress (ACC state).

Function
REQ-003 The block SHALL use a 3-state FSM: IDLE, ACC, DONE.
REQ-004 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-005 A beat SHALL be accepted when in_valid and in_ready are both 1 at a clk edge.
REQ-006 Per accepted beat, the block SHALL unroll DATA_W serial steps in one cycle.
- Each step: fb = crc[CRC_W-1] ^ d; crc = (crc << 1) ^ (fb ? POLY : 0).
- d is taken MSB-first, or LSB-first when REFIN=1.
REQ-007 On the first beat of a frame (accepted in IDLE), the update SHALL start from INIT rather than the stored register, and in_chk SHALL be latched for that frame.
REQ-008 IDLE SHALL go to ACC on an accepted beat with in_last=0, and to DONE on an accepted beat with in_last=1 (single-beat frame).
REQ-009 ACC SHALL stay in ACC on beats with in_last=0, and go to DONE on an accepted beat with in_last=1.
REQ-010 On entering DONE, the block SHALL register the result, giving one cycle of latency from the last beat to out_valid=1.
- crc_out = (REFOUT ? reverse(crc) : crc) ^ XOROUT.
- crc_error = latched in_chk & (crc_out != RESIDUE).
- crc_error is forced to 0 in generate mode.
REQ-011 In DONE, out_valid, crc_out, crc_error and out_len SHALL hold stable until out_valid & out_ready, then the FSM SHALL return to IDLE with out_valid=0 on the next cycle.
REQ-012 out_len SHALL count accepted beats in the frame, including the last, reset to 1 on the first beat and saturating at all ones.
REQ-013 abort=1 in ACC SHALL return the FSM to IDLE with no output, and any beat accepted in the same cycle SHALL be discarded.
- abort in IDLE or DONE SHALL have no effect.
REQ-014 busy SHALL be 1 only in ACC.
REQ-015 Register contents SHALL not change in a cycle with no accepted beat, so in_valid gaps are allowed within a frame.

Reset
REQ-016 rst_n=0 SHALL asynchronously force the following:
- FSM to IDLE.
- CRC register to INIT.
- out_valid, crc_error and busy to 0.
- crc_out and out_len to 0.
- latched mode to 0.
REQ-017 Reset asserted mid-frame or in DONE SHALL discard the frame, and the first beat after release SHALL start a new frame.

Verification
REQ-018 Defaults, generate mode, bytes 0x31..0x39 ("123456789") with a random in_valid gap -> crc_out=16'h29B1, out_len=9, crc_error=0.
REQ-019 Check mode, the same 9 bytes followed by 0x29, 0xB1 -> crc_out=0, crc_error=0, out_len=11; with the last byte 0xB0 -> crc_error=1.
REQ-020 Single-beat frame 0x00 with in_last=1 -> out_valid one cycle later, crc_out=16'hE1F0, in_ready=0 while out_ready is held low for 5 cycles, and outputs stay stable.
REQ-021 Abort after 4 beats, then a clean "123456789" frame -> no out_valid for the aborted frame, and the second frame gives 16'h29B1.
REQ-022 rst_n pulse asynchronous to clk mid-frame -> out_valid=0, busy=0 immediately, and the next frame gives the correct CRC.
REQ-023 CRC_W=32, POLY=32'h04C11DB7, INIT all ones, REFIN=REFOUT=1, XOROUT all ones, generate mode on "123456789" -> 32'hCBF43926.

Source files
------------

// File: rtl/crc_frame_engine.sv
// crc_frame_engine: framed CRC generator/checker, one DATA_W-bit beat per cycle,
// results held in DONE until the consumer takes them.
module crc_frame_engine #(
   parameter int                 CRC_W   = 16,
   parameter int                 DATA_W  = 8,
   parameter logic [CRC_W-1:0]   POLY    = 16'h1021,
   parameter logic [CRC_W-1:0]   INIT    = '1,
   parameter logic [CRC_W-1:0]   XOROUT  = '0,
   parameter bit                 REFIN   = 1'b0,
   parameter bit                 REFOUT  = 1'b0,
   parameter logic [CRC_W-1:0]   RESIDUE = '0,
   parameter int                 LEN_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              in_chk,
   input  logic              abort,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CRC_W-1:0]  crc_out,
   output logic              crc_error,
   output logic [LEN_W-1:0]  out_len,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t             state_q;
   logic [CRC_W-1:0]   crc_q, crc_d, res_d, crc_out_q;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               chk_q, chk_d, err_q, valid_q, busy_q, acc, first;

   function automatic logic [CRC_W-1:0] step(input logic [CRC_W-1:0] c, input logic [DATA_W-1:0] d);
      logic fb;
      for (int i = 0; i < DATA_W; i++) begin
         fb = c[CRC_W-1] ^ (REFIN ? d[i] : d[DATA_W-1-i]);
         c  = (c << 1) ^ (fb ? POLY : '0);
      end
      return c;
   endfunction

   function automatic logic [CRC_W-1:0] rev(input logic [CRC_W-1:0] c);
      for (int i = 0; i < CRC_W; i++) rev[i] = c[CRC_W-1-i];
   endfunction

   assign in_ready  = state_q != DONE;
   assign out_valid = valid_q;
   assign crc_out   = crc_out_q;
   assign crc_error = err_q;
   assign out_len   = len_q;
   assign busy      = busy_q;

   // A beat taken in IDLE opens a new frame: seed from INIT and relatch the mode.
   always_comb begin
      acc   = in_valid & in_ready;
      first = state_q == IDLE;
      crc_d = step(first ? INIT : crc_q, in_data);
      len_d = first ? LEN_W'(1) : (&len_q ? len_q : len_q + 1'b1);
      chk_d = first ? in_chk : chk_q;
      res_d = (REFOUT ? rev(crc_d) : crc_d) ^ XOROUT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         crc_q     <= INIT;
         len_q     <= '0;
         chk_q     <= 1'b0;
         crc_out_q <= '0;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else if (state_q == DONE) begin
         if (out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
         end
      end else if (state_q == ACC && abort) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end else if (acc) begin
         crc_q   <= crc_d;
         len_q   <= len_d;
         chk_q   <= chk_d;
         state_q <= in_last ? DONE : ACC;
         busy_q  <= !in_last;
         valid_q <= in_last;
         if (in_last) begin
            crc_out_q <= res_d;
            err_q     <= chk_d & (res_d != RESIDUE);
         end
      end
   end
endmodule
